// File: rtl/pc_fetch_stage_if.sv
// Instruction-memory port of the fetch stage: address out, combinational read data back.
interface pc_fetch_stage_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;

    modport master (
        output imem_addr,
        input  imem_rdata
    );

    modport slave (
        input  imem_addr,
        output imem_rdata
    );
endinterface

// File: rtl/pc_fetch_stage.sv
// MIPS IF stage: program counter, next-PC selection and the IF/ID pipeline register.
// Kernel mode is carried in bit 31 of the PC and exposed from the ID-side PC+4.
module pc_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [31:0] IRQ_VEC  = 32'h8000_0004,
    parameter logic [31:0] EXC_VEC  = 32'h8000_0008
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     stall,
    input  logic                     branch_taken_ex,
    input  logic [31:0]              branch_target_ex,
    input  logic [2:0]               pcsrc_id,
    input  logic [31:0]              jr_target_id,
    pc_fetch_stage_if.master         imem,
    output logic [31:0]              pc,
    output logic [31:0]              if_id_instr,
    output logic [31:0]              if_id_pc_plus4,
    output logic                     if_id_valid,
    output logic                     ker
);

    localparam logic [2:0] PCSRC_SEQ    = 3'b000;
    localparam logic [2:0] PCSRC_BRANCH = 3'b001;
    localparam logic [2:0] PCSRC_JUMP   = 3'b010;
    localparam logic [2:0] PCSRC_JR     = 3'b011;
    localparam logic [2:0] PCSRC_IRQ    = 3'b100;
    localparam logic [2:0] PCSRC_EXC    = 3'b101;

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_plus4_q, pc_plus4_d;
    logic        valid_q, valid_d;

    logic [31:0] seq_pc;
    logic [31:0] redirect_target;
    logic        redirect_req;
    logic        redirect_take;

    // Bit 31 is the mode bit and never carries in from the +4.
    always_comb begin
        seq_pc = {pc_q[31], pc_q[30:0] + 31'd4};
    end

    // Decode the ID-stage redirect request; branches resolve in EX and are not handled here.
    always_comb begin
        redirect_req    = 1'b0;
        redirect_target = seq_pc;
        case (pcsrc_id)
            PCSRC_JUMP: begin
                redirect_req    = 1'b1;
                redirect_target = {pc_plus4_q[31:28], instr_q[25:0], 2'b00};
            end
            PCSRC_JR: begin
                redirect_req    = 1'b1;
                redirect_target = jr_target_id;
            end
            PCSRC_IRQ: begin
                redirect_req    = 1'b1;
                redirect_target = IRQ_VEC;
            end
            PCSRC_EXC: begin
                redirect_req    = 1'b1;
                redirect_target = EXC_VEC;
            end
            PCSRC_SEQ, PCSRC_BRANCH: begin
                redirect_req = 1'b0;
            end
            default: begin
                redirect_req = 1'b0;
            end
        endcase
        redirect_take = redirect_req & valid_q;
    end

    // Priority: EX branch, then stall, then ID redirect, then sequential fetch.
    always_comb begin
        pc_d       = pc_q;
        instr_d    = instr_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;

        if (branch_taken_ex) begin
            pc_d       = branch_target_ex;
            instr_d    = 32'h0000_0000;
            pc_plus4_d = seq_pc;
            valid_d    = 1'b0;
        end else if (stall) begin
            pc_d       = pc_q;
            instr_d    = instr_q;
            pc_plus4_d = pc_plus4_q;
            valid_d    = valid_q;
        end else if (redirect_take) begin
            // Bubble still takes the fetched PC+4 so ker follows the current mode.
            pc_d       = redirect_target;
            instr_d    = 32'h0000_0000;
            pc_plus4_d = seq_pc;
            valid_d    = 1'b0;
        end else begin
            pc_d       = seq_pc;
            instr_d    = imem.imem_rdata;
            pc_plus4_d = seq_pc;
            valid_d    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            instr_q    <= 32'h0000_0000;
            pc_plus4_q <= RESET_PC;
            valid_q    <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
        end
    end

    assign imem.imem_addr     = pc_q;
    assign pc                 = pc_q;
    assign if_id_instr        = instr_q;
    assign if_id_pc_plus4     = pc_plus4_q;
    assign if_id_valid        = valid_q;
    assign ker                = pc_plus4_q[31];

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Bench for pc_fetch_stage: directed scenarios then randomized traffic against a behavioural model.
module tb_pc_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam logic [31:0] IRQ_VEC  = 32'h8000_0004;
    localparam logic [31:0] EXC_VEC  = 32'h8000_0008;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch_taken_ex;
    logic [31:0] branch_target_ex;
    logic [2:0]  pcsrc_id;
    logic [31:0] jr_target_id;
    logic [31:0] pc;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
    logic        ker;

    logic        use_ovr;
    logic [31:0] ovr_word;

    int tests_run    = 0;
    int tests_failed = 0;

    // Model state
    logic [31:0] m_pc, m_instr, m_pp4;
    logic        m_valid;

    pc_fetch_stage_if imem_bus ();

    pc_fetch_stage dut (
        .clk              (clk),
        .reset            (reset),
        .stall            (stall),
        .branch_taken_ex  (branch_taken_ex),
        .branch_target_ex (branch_target_ex),
        .pcsrc_id         (pcsrc_id),
        .jr_target_id     (jr_target_id),
        .imem             (imem_bus),
        .pc               (pc),
        .if_id_instr      (if_id_instr),
        .if_id_pc_plus4   (if_id_pc_plus4),
        .if_id_valid      (if_id_valid),
        .ker              (ker)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] imem_word(input logic [31:0] addr);
        return (addr ^ 32'h5A3C_0000) | 32'h0000_0001;
    endfunction

    assign imem_bus.imem_rdata = use_ovr ? ovr_word : imem_word(imem_bus.imem_addr);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic set_idle();
        reset            = 1'b0;
        stall            = 1'b0;
        branch_taken_ex  = 1'b0;
        branch_target_ex = 32'h0;
        pcsrc_id         = 3'b000;
        jr_target_id     = 32'h0;
        use_ovr          = 1'b0;
        ovr_word         = 32'h0;
    endtask

    task automatic model_reset();
        m_pc    = RESET_PC;
        m_instr = 32'h0;
        m_pp4   = RESET_PC;
        m_valid = 1'b0;
    endtask

    // Compare DUT against model, then advance both across one clock edge.
    task automatic cycle(input string tag);
        logic [31:0] fetched, seq, tgt;
        logic [31:0] n_pc, n_instr, n_pp4;
        logic        n_valid, redir;

        check_eq({tag, ":pc"},    pc,                       m_pc);
        check_eq({tag, ":addr"},  imem_bus.imem_addr,       m_pc);
        check_eq({tag, ":instr"}, if_id_instr,              m_instr);
        check_eq({tag, ":pp4"},   if_id_pc_plus4,           m_pp4);
        check_eq({tag, ":valid"}, {31'd0, if_id_valid},     {31'd0, m_valid});
        check_eq({tag, ":ker"},   {31'd0, ker},             {31'd0, m_pp4 >= 32'h8000_0000});

        fetched = use_ovr ? ovr_word : imem_word(m_pc);
        // Mode bit kept, lower 31 bits wrap.
        seq = (m_pc & 32'h8000_0000) | ((m_pc + 32'd4) & 32'h7FFF_FFFF);
        redir = 1'b0;
        tgt   = 32'h0;
        if (m_valid) begin
            if (pcsrc_id == 3'd2) begin
                redir = 1'b1;
                tgt = (m_pp4 & 32'hF000_0000) | ((m_instr & 32'h03FF_FFFF) * 4);
            end else if (pcsrc_id == 3'd3) begin
                redir = 1'b1; tgt = jr_target_id;
            end else if (pcsrc_id == 3'd4) begin
                redir = 1'b1; tgt = IRQ_VEC;
            end else if (pcsrc_id == 3'd5) begin
                redir = 1'b1; tgt = EXC_VEC;
            end
        end

        n_pc = m_pc; n_instr = m_instr; n_pp4 = m_pp4; n_valid = m_valid;
        if (reset) begin
            n_pc = RESET_PC; n_instr = 32'h0; n_pp4 = RESET_PC; n_valid = 1'b0;
        end else if (branch_taken_ex) begin
            n_pc = branch_target_ex; n_instr = 32'h0; n_pp4 = seq; n_valid = 1'b0;
        end else if (stall) begin
            // hold everything
        end else if (redir) begin
            n_pc = tgt; n_instr = 32'h0; n_pp4 = seq; n_valid = 1'b0;
        end else begin
            n_pc = seq; n_instr = fetched; n_pp4 = seq; n_valid = 1'b1;
        end

        @(posedge clk);
        #1;
        m_pc = n_pc; m_instr = n_instr; m_pp4 = n_pp4; m_valid = n_valid;
    endtask

    task automatic branch_to(input logic [31:0] tgt);
        set_idle();
        branch_taken_ex  = 1'b1;
        branch_target_ex = tgt;
        cycle("br");
        set_idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        set_idle();
        reset = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        set_idle();

        // Reset values
        check_eq("rst_pc",    pc,                   RESET_PC);
        check_eq("rst_instr", if_id_instr,          32'h0);
        check_eq("rst_pp4",   if_id_pc_plus4,       RESET_PC);
        check_eq("rst_valid", {31'd0, if_id_valid}, 32'h0);
        check_eq("rst_ker",   {31'd0, ker},         32'h1);

        // Free-running fetch
        for (int i = 1; i <= 4; i++) begin
            cycle("seq");
            check_eq("seq_pc",    pc,                   RESET_PC + 32'(i * 4));
            check_eq("seq_pp4",   if_id_pc_plus4,       RESET_PC + 32'(i * 4));
            check_eq("seq_valid", {31'd0, if_id_valid}, 32'h1);
            check_eq("seq_ker",   {31'd0, ker},         32'h1);
        end

        // j with target 26'h10 from if_id_pc_plus4 = 0000_1008
        branch_to(32'h0000_1004);
        use_ovr = 1'b1; ovr_word = {6'b000010, 26'h000_0010};
        cycle("jfetch");
        set_idle();
        check_eq("j_pp4", if_id_pc_plus4, 32'h0000_1008);
        pcsrc_id = 3'b010;
        cycle("j");
        check_eq("j_pc",    pc,                   32'h0000_0040);
        check_eq("j_instr", if_id_instr,          32'h0);
        check_eq("j_valid", {31'd0, if_id_valid}, 32'h0);
        cycle("j_inval");
        check_eq("j_inval_pc", pc, 32'h0000_0044);
        set_idle();

        // jr from kernel with a two-cycle stall
        branch_to(32'h8000_0100);
        cycle("jrfetch");
        pcsrc_id = 3'b011; jr_target_id = 32'h0000_3000; stall = 1'b1;
        cycle("jr_st1");
        check_eq("jr_hold1", pc, 32'h8000_0104);
        cycle("jr_st2");
        check_eq("jr_hold2", pc, 32'h8000_0104);
        check_eq("jr_hold_valid", {31'd0, if_id_valid}, 32'h1);
        stall = 1'b0;
        cycle("jr");
        check_eq("jr_pc",  pc,           32'h0000_3000);
        check_eq("jr_ker", {31'd0, ker}, 32'h1);
        set_idle();
        cycle("jr_next");
        check_eq("jr_ker_drop", {31'd0, ker}, 32'h0);

        // Branch beats stall and interrupt
        cycle("pre_br");
        branch_taken_ex = 1'b1; branch_target_ex = 32'h0000_0200;
        stall = 1'b1; pcsrc_id = 3'b100;
        cycle("br_win");
        check_eq("brw_pc",    pc,                   32'h0000_0200);
        check_eq("brw_valid", {31'd0, if_id_valid}, 32'h0);
        set_idle();

        // Interrupt then exception on a valid user instruction
        for (int k = 0; k < 2; k++) begin
            branch_to(32'h0000_0100);
            cycle("vfetch");
            pcsrc_id = (k == 0) ? 3'b100 : 3'b101;
            check_eq("vec_pp4", if_id_pc_plus4, 32'h0000_0104);
            cycle("vec");
            check_eq("vec_pc", pc, (k == 0) ? IRQ_VEC : EXC_VEC);
            set_idle();
        end

        // PC wrap in both modes, then reset mid-stream
        branch_to(32'h7FFF_FFFC);
        cycle("wrap_u");
        check_eq("wrap_u_pc", pc, 32'h0000_0000);
        branch_to(32'hFFFF_FFFC);
        cycle("wrap_k");
        check_eq("wrap_k_pc", pc, 32'h8000_0000);
        branch_to(32'h0000_0500);
        cycle("pre_rst");
        reset = 1'b1; stall = 1'b1; branch_taken_ex = 1'b1;
        branch_target_ex = 32'h1234_5678; pcsrc_id = 3'b011;
        cycle("mid_rst");
        check_eq("mrst_pc",    pc,                   RESET_PC);
        check_eq("mrst_instr", if_id_instr,          32'h0);
        check_eq("mrst_pp4",   if_id_pc_plus4,       RESET_PC);
        check_eq("mrst_valid", {31'd0, if_id_valid}, 32'h0);
        check_eq("mrst_ker",   {31'd0, ker},         32'h1);
        set_idle();

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            reset            = ($urandom_range(99) < 2);
            branch_taken_ex  = ($urandom_range(99) < 10);
            stall            = ($urandom_range(99) < 20);
            branch_target_ex = $urandom;
            if ($urandom_range(3) == 0)
                branch_target_ex[30:0] = 31'h7FFF_FFF8 | 31'($urandom_range(7));
            pcsrc_id         = 3'($urandom_range(7));
            jr_target_id     = $urandom;
            use_ovr          = $urandom_range(1) == 1;
            ovr_word         = $urandom;
            cycle("rnd");
        end
        set_idle();
        cycle("final");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
